// File: rtl/asgn_op_pkg.sv
// Shared types and helpers for the compound-assignment engine.
// Shift helpers work on a 64-bit container, so WIDTH is limited to 8..64.
package asgn_op_pkg;

  localparam int SH_MAXW = 64;

  typedef enum logic [3:0] {
    OP_SET = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_SHL = 4'd4,
    OP_SHR = 4'd5,
    OP_ASR = 4'd6,
    OP_INC = 4'd7,
    OP_DEC = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_legal(op_e op);
    return (4'(op) <= 4'(OP_DEC));
  endfunction

  // a must arrive sign-extended to SH_MAXW and b zero-extended; any b >= width saturates.
  function automatic logic [SH_MAXW-1:0] shift_op(op_e op, logic [SH_MAXW-1:0] a,
                                                  logic [SH_MAXW-1:0] b, int unsigned width);
    logic             big;
    logic [5:0]       sh;
    logic [SH_MAXW-1:0] mask;
    logic [SH_MAXW-1:0] res;
    big  = (b >= 64'(width));
    sh   = b[5:0];
    mask = (width >= 32'd64) ? '1 : ((64'd1 << width) - 64'd1);
    res  = a;
    case (op)
      OP_SHL:  res = big ? '0 : (a << sh);
      OP_SHR:  res = big ? '0 : ((a & mask) >> sh);
      OP_ASR:  res = big ? {SH_MAXW{a[SH_MAXW-1]}} : ($signed(a) >>> sh);
      default: res = a;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/asgn_op_engine_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// o_done pulses on the last busy cycle with o_product already complete.
module asgn_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_sum;

  // Product exposed combinationally so the final bit lands in the same cycle as o_done.
  assign w_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_product = w_sum;
  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= CW'(WIDTH - 1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/asgn_op_engine.sv
// Register file plus one-at-a-time compound-assignment executor with a
// valid/ready command channel and a valid/ready old/new response channel.
module asgn_op_engine
  import asgn_op_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 4,
  parameter int RAW   = $clog2(NREG)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [3:0]       i_cmd_op,
  input  logic [RAW-1:0]   i_cmd_dst,
  input  logic [RAW-1:0]   i_cmd_src,
  input  logic             i_cmd_use_imm,
  input  logic [WIDTH-1:0] i_cmd_imm,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [RAW-1:0]   o_rsp_dst,
  output logic [WIDTH-1:0] o_rsp_old,
  output logic [WIDTH-1:0] o_rsp_new,
  output logic             o_rsp_err,
  input  logic [RAW-1:0]   i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_regs [NREG];
  state_e           r_state;
  state_e           w_next_state;
  logic [RAW-1:0]   r_rsp_dst;
  logic [WIDTH-1:0] r_rsp_old;
  logic [WIDTH-1:0] r_rsp_new;
  logic             r_rsp_err;

  op_e              w_op;
  logic             w_legal;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_alu;
  logic             w_wr_en;
  logic [RAW-1:0]   w_wr_idx;
  logic [WIDTH-1:0] w_wr_data;

  // Operands come from the pre-edge register file, so a command never sees its own write.
  assign w_op    = op_e'(i_cmd_op);
  assign w_legal = is_legal(w_op);
  assign w_a     = r_regs[i_cmd_dst];
  assign w_b     = i_cmd_use_imm ? i_cmd_imm : r_regs[i_cmd_src];

  always_comb begin
    w_alu = w_a;
    case (w_op)
      OP_SET:                 w_alu = w_b;
      OP_ADD:                 w_alu = w_a + w_b;
      OP_SUB:                 w_alu = w_a - w_b;
      OP_SHL, OP_SHR, OP_ASR: w_alu = WIDTH'(shift_op(w_op, 64'($signed(w_a)), 64'(w_b), WIDTH));
      OP_INC:                 w_alu = w_a + WIDTH'(1);
      OP_DEC:                 w_alu = w_a - WIDTH'(1);
      default:                w_alu = w_a;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_cmd_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    w_accept     = 1'b0;
    w_mul_start  = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_accept = 1'b1;
          if (w_op == OP_MUL) begin
            w_mul_start  = 1'b1;
            w_next_state = MUL;
          end else begin
            w_next_state = RESP;
          end
        end
      end
      MUL: begin
        if (w_mul_done)      w_next_state = RESP;
        else if (!w_mul_busy) w_next_state = IDLE;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_wr_en   = (w_accept && w_legal && (w_op != OP_MUL)) || ((r_state == MUL) && w_mul_done);
  assign w_wr_idx  = w_accept ? i_cmd_dst : r_rsp_dst;
  assign w_wr_data = w_accept ? w_alu : w_mul_product;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_wr_idx] <= w_wr_data;
    end
  end

  // Illegal opcodes fall through the ALU default, so rsp_new naturally equals rsp_old.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_dst <= '0;
      r_rsp_old <= '0;
      r_rsp_new <= '0;
      r_rsp_err <= 1'b0;
    end else if (w_accept) begin
      r_rsp_dst <= i_cmd_dst;
      r_rsp_old <= w_a;
      r_rsp_new <= w_alu;
      r_rsp_err <= !w_legal;
    end else if ((r_state == MUL) && w_mul_done) begin
      r_rsp_new <= w_mul_product;
    end
  end

  asgn_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (w_mul_start),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  assign o_rsp_dst = r_rsp_dst;
  assign o_rsp_old = r_rsp_old;
  assign o_rsp_new = r_rsp_new;
  assign o_rsp_err = r_rsp_err;
  assign o_rd_data = r_regs[i_rd_addr];

endmodule

// File: doc/asgn_op_engine.md
Name: asgn_op_engine

Overview:
Sequential compound-assignment engine: holds NREG signed WIDTH-bit registers and executes one command at a time: =, +=, -=, *=, <<=, >>=, >>>=, ++, --.
Accepts commands on a valid/ready channel and returns old and new destination values on a valid/ready response channel, so the consumer selects pre-/post-increment semantics.
Sits downstream of the command generator and upstream of the checker, which compares responses against expected values.

Parameters:
WIDTH, 32, register and operand width in bits (power of two, >=8)
NREG, 4, number of registers; RAW = $clog2(NREG)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  engine can accept a command
cmd_op  in  4  opcode (see package)
cmd_dst  in  RAW  destination register index
cmd_src  in  RAW  source register index
cmd_use_imm  in  1  1: operand = cmd_imm; 0: operand = reg[cmd_src]
cmd_imm  in  WIDTH  immediate operand
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_dst  out  RAW  destination index of the completed command
rsp_old  out  WIDTH  dst value before the operation
rsp_new  out  WIDTH  dst value after the operation
rsp_err  out  1  illegal opcode; register unchanged
rd_addr  in  RAW  debug read index
rd_data  out  WIDTH  reg[rd_addr], combinational

Behaviour:
- Reset: all registers 0; state IDLE; cmd_ready=1; rsp_valid=0; rsp_dst/old/new/err=0.
- FSM states: IDLE, MUL, RESP.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) captures the command and latches operand A=reg[dst], B=operand.
  - Single-cycle ops: reg[dst] written at the accept edge; go to RESP. rsp_valid rises the cycle after accept (latency 1).
  - MUL: go to MUL.
- MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles. reg[dst] written on the last cycle; then RESP. rsp_valid rises WIDTH+1 cycles after accept.
- RESP: rsp_valid=1 and all rsp_* held stable until rsp_ready, then IDLE. cmd_ready=0 in MUL and RESP, so the engine executes no overlapping commands. Peak throughput is one single-cycle op per 2 cycles when rsp_ready=1.
- Opcodes:
  - SET=0: dst = B
  - ADD=1: dst += B
  - SUB=2: dst -= B
  - MUL=3: dst *= B
  - SHL=4: dst <<= B
  - SHR=5: logical dst >>= B
  - ASR=6: arithmetic dst >>>= B
  - INC=7: ++dst (B ignored)
  - DEC=8: --dst (B ignored)
  - 9..15: illegal; rsp_err=1, rsp_new=rsp_old, no write, latency 1.
- Arithmetic: all results truncated mod 2^WIDTH (two's-complement wrap). 0x7FFF_FFFF INC gives 0x8000_0000; 0 DEC gives all-ones. MUL keeps the low WIDTH bits of the product; signed and unsigned agree there.
- Shift amount: B is always treated as unsigned. If B >= WIDTH: SHL/SHR give 0, ASR gives all sign bits. B = all-ones therefore counts as a huge shift, not -1.
- dst==src with cmd_use_imm=0: B is the pre-operation value (x += x doubles; x *= x squares).
- rd_data reflects a write from the edge after it occurs. A command never observes its own write as an operand.
- Reset mid-MUL or mid-RESP: immediate abort, all registers 0, no response emitted.
- rsp_ready high while rsp_valid is low has no effect.

Decomposition:
- Package asgn_op_pkg:
  - op_e enum (values above)
  - state_e enum {IDLE, MUL, RESP}
  - function is_legal(op_e)
  - function shift_op(op, a, b), implementing the >= WIDTH saturation rules
- Sub-module asgn_seq_mul: iterative WIDTH-cycle multiplier.
  - Inputs: start, a, b.
  - Outputs: busy, done (1-cycle pulse), product.
  - Own async active-low reset.

Test Plan:
- SET r2,imm 99; SET r1,src r2; ADD r1,imm 1 -> rsp_new 99, 99, 100; rd_data(r1)=100; each rsp_valid exactly 1 cycle after accept.
- MUL r1,imm 2 with r1=100 -> rsp_old=100, rsp_new=200; rsp_valid 33 cycles after accept; cmd_ready=0 throughout; MUL r3,src r3 with r3=0x10000 -> rsp_new 0 (wrap).
- r2=99: SHR imm 2 -> 24; SHR imm all-ones -> 0; r0=-8 ASR imm 1 -> -4; ASR imm 40 -> -1; SHL imm 32 -> 0.
- r0=0: INC -> rsp_old=0, rsp_new=1; DEC, DEC -> rsp_new=-1 (all-ones); INC on 0x7FFFFFFF -> 0x80000000; opcode 12 -> rsp_err=1, register unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_* stable, cmd_ready=0, second command not accepted until the cycle after rsp_ready=1.
- Assert rst_n=0 on MUL cycle 10 -> rsp_valid never rises, all rd_data=0, cmd_ready=1 after release; next SET completes normally.
